// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR shift-register generator and checker.
// Taps 7 and 3, shift left, feedback into bit 0.
package lfsr_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int TAP_HI = 7;
  localparam int TAP_LO = 3;

  localparam logic [7:0] LOCKUP = 8'hFF;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] x
  );
    return {x[6:0], ~(x[TAP_HI] ^ x[TAP_LO])};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Sample stream and status bundle between
// the generator side and the pattern checker.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);

  logic             enable;
  logic [7:0]       data_in;
  logic             err_clear;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             stuck;

  modport master (
    output enable,
    output data_in,
    output err_clear,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  stuck
  );

  modport slave (
    input  enable,
    input  data_in,
    input  err_clear,
    output locked,
    output err_pulse,
    output err_count,
    output stuck
  );

endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising pattern checker for the XNOR
// shift-register stream, with a saturating error counter.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input logic          clk,
  input logic          reset,
  lfsr_checker_if.slave bus
);

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_C = 8'(LOSS_COUNT);

  state_t           state;
  logic [7:0]       model;
  logic             have_prev;
  logic [7:0]       match_cnt;
  logic [7:0]       miss_cnt;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             stuck;

  logic       miss;
  logic       hit;
  logic [7:0] match_nxt;
  logic [7:0] miss_nxt;

  assign miss      = bus.data_in != model;
  assign hit       = !miss && (bus.data_in != LOCKUP);
  assign match_nxt = match_cnt + 8'd1;
  assign miss_nxt  = miss_cnt + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      model     <= 8'h00;
      have_prev <= 1'b0;
      match_cnt <= 8'd0;
      miss_cnt  <= 8'd0;
      err_pulse <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (bus.enable) begin
        stuck <= bus.data_in == LOCKUP;
        unique case (state)
          SEARCH: begin
            model <= lfsr_step(bus.data_in);
            if (!have_prev) begin
              have_prev <= 1'b1;
            end else if (hit && match_nxt == LOCK_C) begin
              state     <= LOCKED;
              match_cnt <= 8'd0;
              miss_cnt  <= 8'd0;
            end else if (hit) begin
              match_cnt <= match_nxt;
            end else begin
              match_cnt <= 8'd0;
            end
          end
          LOCKED: begin
            // Free-running: never reseed from the line.
            model <= lfsr_step(model);
            if (miss) begin
              err_pulse <= 1'b1;
              if (miss_nxt == LOSS_C) begin
                state     <= SEARCH;
                have_prev <= 1'b0;
                match_cnt <= 8'd0;
                miss_cnt  <= 8'd0;
              end else begin
                miss_cnt <= miss_nxt;
              end
            end else begin
              miss_cnt <= 8'd0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (bus.err_clear) begin
      err_count <= '0;
    end else if (bus.enable && state == LOCKED
                 && miss && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign bus.locked    = state == LOCKED;
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;
  assign bus.stuck     = stuck;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, errors, loss,
// lock-up word, enable gaps, saturation, async reset.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(4)) bus ();

  lfsr_checker #(
    .LOCK_COUNT(8),
    .LOSS_COUNT(4),
    .ERR_W     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int idx    = 0;

  // Hand-computed cycle through 8'h00.
  logic [7:0] seq [12] = '{
    8'h00, 8'h01, 8'h03, 8'h07,
    8'h0F, 8'h1E, 8'h3C, 8'h78,
    8'hF0, 8'hE0, 8'hC0, 8'h80
  };

  logic [7:0] v;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic       en,
    input logic [7:0] d,
    input logic       clr
  );
    @(negedge clk);
    bus.enable    = en;
    bus.data_in   = d;
    bus.err_clear = clr;
    @(posedge clk);
    #1;
    bus.enable    = 1'b0;
    bus.err_clear = 1'b0;
  endtask

  task automatic good();
    drive(1'b1, seq[idx], 1'b0);
    idx = (idx + 1) % 12;
  endtask

  task automatic bad(input logic [7:0] d);
    drive(1'b1, d, 1'b0);
    idx = (idx + 1) % 12;
  endtask

  initial begin
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.data_in   = 8'h00;
    bus.err_clear = 1'b0;
    #12;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_pulse", 32'(bus.err_pulse), 0);
    chk("rst_count", 32'(bus.err_count), 0);
    chk("rst_stuck", 32'(bus.stuck), 0);
    @(negedge clk);
    reset = 1'b1;

    // Lock from reset: 1 seed + 8 matches.
    for (int i = 0; i < 8; i++) begin
      good();
      chk("lock_wait", 32'(bus.locked), 0);
    end
    good();
    chk("lock_rise", 32'(bus.locked), 1);
    chk("lock_count", 32'(bus.err_count), 0);

    // Single corrupted word (E1 for E0).
    bad(8'hE1);
    chk("single_pulse", 32'(bus.err_pulse), 1);
    chk("single_count", 32'(bus.err_count), 1);
    chk("single_lock", 32'(bus.locked), 1);
    good();
    chk("single_pulse_end", 32'(bus.err_pulse), 0);
    chk("single_no_burst", 32'(bus.err_count), 1);
    good();
    good();
    chk("single_hold_lock", 32'(bus.locked), 1);
    chk("single_hold_cnt", 32'(bus.err_count), 1);

    // Enable-low gaps with garbage.
    drive(1'b0, 8'hAA, 1'b0);
    drive(1'b0, 8'hFF, 1'b0);
    drive(1'b0, 8'h5C, 1'b0);
    chk("gap_pulse", 32'(bus.err_pulse), 0);
    chk("gap_stuck", 32'(bus.stuck), 0);
    chk("gap_count", 32'(bus.err_count), 1);
    chk("gap_lock", 32'(bus.locked), 1);
    good();
    good();
    chk("gap_resume_pulse", 32'(bus.err_pulse), 0);
    chk("gap_resume_cnt", 32'(bus.err_count), 1);

    // Clear alone, then loss of lock.
    drive(1'b0, 8'h00, 1'b1);
    chk("clear_count", 32'(bus.err_count), 0);
    for (int i = 0; i < 4; i++) begin
      bad(8'hAA);
      chk("loss_count", 32'(bus.err_count), 32'(i + 1));
      chk("loss_pulse", 32'(bus.err_pulse), 1);
      chk("loss_lock", 32'(bus.locked), (i < 3) ? 1 : 0);
    end

    // Clean restart relocks after 1 + 8 samples.
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      good();
      chk("relock_wait", 32'(bus.locked), 0);
    end
    good();
    chk("relock_rise", 32'(bus.locked), 1);
    chk("relock_count", 32'(bus.err_count), 4);

    // Saturation with ERR_W=4.
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      v = seq[idx] ^ 8'h01;
      bad(v);
      good();
    end
    chk("sat_count", 32'(bus.err_count), 15);
    chk("sat_lock", 32'(bus.locked), 1);

    // Clear wins over a simultaneous error.
    v = seq[idx] ^ 8'h01;
    drive(1'b1, v, 1'b1);
    idx = (idx + 1) % 12;
    chk("clr_err_count", 32'(bus.err_count), 0);
    chk("clr_err_pulse", 32'(bus.err_pulse), 1);
    good();
    chk("clr_after_cnt", 32'(bus.err_count), 0);

    // Async reset while locked, between edges.
    bad(8'hFF);
    chk("pre_rst_stuck", 32'(bus.stuck), 1);
    chk("pre_rst_count", 32'(bus.err_count), 1);
    chk("pre_rst_lock", 32'(bus.locked), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_lock", 32'(bus.locked), 0);
    chk("arst_count", 32'(bus.err_count), 0);
    chk("arst_stuck", 32'(bus.stuck), 0);
    chk("arst_pulse", 32'(bus.err_pulse), 0);
    @(negedge clk);
    reset = 1'b1;

    // Lock-up word never locks.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'hFF, 1'b0);
      chk("ff_stuck", 32'(bus.stuck), 1);
      chk("ff_lock", 32'(bus.locked), 0);
      chk("ff_match", 32'(dut.match_cnt), 0);
    end

    // Leaves lock-up and relocks: 1 miss + 8 matches.
    idx = 0;
    good();
    chk("unstuck", 32'(bus.stuck), 0);
    for (int i = 0; i < 7; i++) begin
      good();
      chk("ff_relock_wait", 32'(bus.locked), 0);
    end
    good();
    chk("ff_relock_rise", 32'(bus.locked), 1);
    chk("ff_relock_cnt", 32'(bus.err_count), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
